// File: rtl/pipe_reg_file.sv
// pipe_reg_file: register file with registered read ports and a pending-bit
// scoreboard that tracks registers awaiting writeback.
// Optional macro PIPE_REG_FILE_BYPASS_EN enables same-edge write-to-read
// forwarding. When it is undefined, a read that coincides with a write to
// the same address returns the old contents.
module pipe_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] readreg1,
    input  logic [ADDR_W-1:0] readreg2,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] writereg,
    input  logic [DATA_W-1:0] writedata,
    input  logic              alloc_en,
    input  logic [ADDR_W-1:0] alloc_reg,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pending_q;
    logic [DEPTH-1:0]  pending_d;

    logic [DATA_W-1:0] read_data1_q;
    logic [DATA_W-1:0] read_data1_d;
    logic [DATA_W-1:0] read_data2_q;
    logic [DATA_W-1:0] read_data2_d;
    logic              busy1_q;
    logic              busy1_d;
    logic              busy2_q;
    logic              busy2_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    logic write_ok;
    logic alloc_ok;
    logic zero_addr1;
    logic zero_addr2;
    logic fwd1;
    logic fwd2;

    // Qualify writes and allocations; address 0 is inert when it is hardwired.
    always_comb begin
        write_ok   = regwrite && !((ZERO_REG != 0) && (writereg == '0));
        alloc_ok   = alloc_en && !((ZERO_REG != 0) && (alloc_reg == '0));
        zero_addr1 = (ZERO_REG != 0) && (readreg1 == '0);
        zero_addr2 = (ZERO_REG != 0) && (readreg2 == '0);
`ifdef PIPE_REG_FILE_BYPASS_EN
        fwd1       = write_ok && (readreg1 == writereg);
        fwd2       = write_ok && (readreg2 == writereg);
`else
        fwd1       = 1'b0;
        fwd2       = 1'b0;
`endif
    end

    // Next register contents and pending bits; the new producer (alloc) wins over a clearing write.
    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        if (write_ok) begin
            regs_d[writereg]    = writedata;
            pending_d[writereg] = 1'b0;
        end
        if (alloc_ok) begin
            pending_d[alloc_reg] = 1'b1;
        end
    end

    // Population count of the post-update pending bits; sized so it can never wrap.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, pending_d[i]};
        end
    end

    // Read port 1: zero register, then forwarded write, then stored contents.
    always_comb begin
        read_data1_d = regs_q[readreg1];
        busy1_d      = pending_q[readreg1];
        if (zero_addr1) begin
            read_data1_d = '0;
            busy1_d      = 1'b0;
        end else if (fwd1) begin
            read_data1_d = writedata;
            busy1_d      = pending_d[readreg1];
        end
    end

    // Read port 2: same selection as port 1, fully independent of it.
    always_comb begin
        read_data2_d = regs_q[readreg2];
        busy2_d      = pending_q[readreg2];
        if (zero_addr2) begin
            read_data2_d = '0;
            busy2_d      = 1'b0;
        end else if (fwd2) begin
            read_data2_d = writedata;
            busy2_d      = pending_d[readreg2];
        end
    end

    // State update; reset clears everything and discards any same-edge write or alloc.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q    <= '0;
            read_data1_q <= '0;
            read_data2_q <= '0;
            busy1_q      <= 1'b0;
            busy2_q      <= 1'b0;
            busy_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pending_q    <= pending_d;
            read_data1_q <= read_data1_d;
            read_data2_q <= read_data2_d;
            busy1_q      <= busy1_d;
            busy2_q      <= busy2_d;
            busy_cnt_q   <= busy_cnt_d;
        end
    end

    assign read_data1 = read_data1_q;
    assign read_data2 = read_data2_q;
    assign busy1      = busy1_q;
    assign busy2      = busy2_q;
    assign busy_cnt   = busy_cnt_q;

endmodule

// File: tb/tb_pipe_reg_file.sv
// tb_pipe_reg_file: directed bench for pipe_reg_file. Each step drives one
// set of inputs, advances one rising edge, then samples the registered outputs.
module tb_pipe_reg_file;

    logic        clk;
    logic        rst;
    logic [4:0]  readreg1;
    logic [4:0]  readreg2;
    logic        regwrite;
    logic [4:0]  writereg;
    logic [31:0] writedata;
    logic        alloc_en;
    logic [4:0]  alloc_reg;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic        busy1;
    logic        busy2;
    logic [5:0]  busy_cnt;

    int checks;
    int errors;

    pipe_reg_file #(
        .DATA_W  (32),
        .ADDR_W  (5),
        .ZERO_REG(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .readreg1  (readreg1),
        .readreg2  (readreg2),
        .regwrite  (regwrite),
        .writereg  (writereg),
        .writedata (writedata),
        .alloc_en  (alloc_en),
        .alloc_reg (alloc_reg),
        .read_data1(read_data1),
        .read_data2(read_data2),
        .busy1     (busy1),
        .busy2     (busy2),
        .busy_cnt  (busy_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and step past the next rising edge.
    task automatic applyStimulus(input logic r, input logic rw, input logic [4:0] wr,
                                 input logic [31:0] wd, input logic ae, input logic [4:0] ar,
                                 input logic [4:0] r1, input logic [4:0] r2);
        rst       = r;
        regwrite  = rw;
        writereg  = wr;
        writedata = wd;
        alloc_en  = ae;
        alloc_reg = ar;
        readreg1  = r1;
        readreg2  = r2;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed sequence covering reset, write/read, hazard, scoreboard, zero register.
    initial begin
        logic [31:0] hazard_exp;
        logic        busy4_exp;
        logic [31:0] exp_cnt;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        regwrite  = 1'b0;
        writereg  = '0;
        writedata = '0;
        alloc_en  = 1'b0;
        alloc_reg = '0;
        readreg1  = '0;
        readreg2  = '0;

        // Reset after random writes and allocations.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(0, 1, 5'(i), $urandom, 1, 5'(i + 10), 0, 0);
        end
        checkOutput("pre_reset_cnt", 32'(busy_cnt), 32'd10);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 11);
        checkOutput("reset_rd1", read_data1, 32'h0);
        checkOutput("reset_busy1", 32'(busy1), 32'h0);
        checkOutput("reset_cnt", 32'(busy_cnt), 32'h0);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
            checkOutput("reset_scan_rd1", read_data1, 32'h0);
            checkOutput("reset_scan_rd2", read_data2, 32'h0);
            checkOutput("reset_scan_busy2", 32'(busy2), 32'h0);
        end
        checkOutput("reset_scan_cnt", 32'(busy_cnt), 32'h0);

        // Write then read back one cycle later.
        applyStimulus(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
        checkOutput("wr_rd_5", read_data1, 32'hDEADBEEF);
        checkOutput("wr_rd_5_busy", 32'(busy1), 32'h0);

        // Same-edge write/read hazard on port 2.
`ifdef PIPE_REG_FILE_BYPASS_EN
        hazard_exp = 32'h1234;
`else
        hazard_exp = 32'h55;
`endif
        applyStimulus(0, 1, 7, 32'h55, 0, 0, 0, 0);
        applyStimulus(0, 1, 7, 32'h1234, 0, 0, 0, 7);
        checkOutput("hazard_rd2", read_data2, hazard_exp);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 7);
        checkOutput("hazard_after", read_data2, 32'h1234);

        // Both ports on the same register.
        applyStimulus(0, 1, 12, 32'hCAFE, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 12, 12);
        checkOutput("dual_rd1", read_data1, 32'hCAFE);
        checkOutput("dual_rd2", read_data2, 32'hCAFE);

        // Scoreboard allocations and releases.
        applyStimulus(0, 0, 0, 0, 1, 3, 0, 0);
        checkOutput("alloc3_cnt", 32'(busy_cnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 4, 3, 0);
        checkOutput("alloc4_cnt", 32'(busy_cnt), 32'd2);
        checkOutput("alloc4_busy3", 32'(busy1), 32'd1);
        applyStimulus(0, 1, 3, 32'h33, 1, 3, 3, 0);
        checkOutput("alloc_wr3_cnt", 32'(busy_cnt), 32'd2);
        checkOutput("alloc_wr3_busy", 32'(busy1), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
        checkOutput("after_wr3_busy", 32'(busy1), 32'd1);
        checkOutput("after_wr3_data", read_data1, 32'h33);
`ifdef PIPE_REG_FILE_BYPASS_EN
        busy4_exp = 1'b0;
`else
        busy4_exp = 1'b1;
`endif
        applyStimulus(0, 1, 4, 32'h44, 0, 0, 0, 4);
        checkOutput("wr4_cnt", 32'(busy_cnt), 32'd1);
        checkOutput("wr4_busy_same_edge", 32'(busy2), 32'(busy4_exp));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4);
        checkOutput("wr4_busy_after", 32'(busy2), 32'd0);
        checkOutput("wr4_data_after", read_data2, 32'h44);
        applyStimulus(0, 0, 0, 0, 1, 3, 0, 0);
        checkOutput("realloc3_cnt", 32'(busy_cnt), 32'd1);
        applyStimulus(0, 1, 10, 32'hA, 0, 0, 0, 0);
        checkOutput("wr_nonpending_cnt", 32'(busy_cnt), 32'd1);
        applyStimulus(0, 1, 3, 32'h3, 1, 6, 0, 0);
        checkOutput("alloc6_wr3_cnt", 32'(busy_cnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 3, 6);
        checkOutput("busy3_cleared", 32'(busy1), 32'd0);
        checkOutput("busy6_set", 32'(busy2), 32'd1);

        // Register zero ignores writes and allocations.
        applyStimulus(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        checkOutput("zero_rd1", read_data1, 32'h0);
        checkOutput("zero_busy1", 32'(busy1), 32'h0);
        checkOutput("zero_cnt", 32'(busy_cnt), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("zero_rd1_after", read_data1, 32'h0);
        checkOutput("zero_busy1_after", 32'(busy1), 32'h0);

        // Fill the scoreboard to its maximum and confirm it saturates at 31.
        for (int i = 1; i < 32; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 5'(i), 0, 0);
            exp_cnt = (i < 6) ? 32'(i + 1) : 32'(i);
            checkOutput("fill_cnt", 32'(busy_cnt), exp_cnt);
        end
        applyStimulus(0, 0, 0, 0, 1, 31, 31, 0);
        checkOutput("full_cnt", 32'(busy_cnt), 32'd31);
        checkOutput("full_busy31", 32'(busy1), 32'd1);

        // Reset dominates a coincident write and allocation.
        applyStimulus(1, 1, 9, 32'hA5, 1, 9, 9, 5);
        checkOutput("mid_reset_cnt", 32'(busy_cnt), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 9, 5);
        checkOutput("mid_reset_rd9", read_data1, 32'h0);
        checkOutput("mid_reset_busy9", 32'(busy1), 32'h0);
        checkOutput("mid_reset_rd5", read_data2, 32'h0);
        checkOutput("mid_reset_cnt_after", 32'(busy_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
